// File: rtl/lfsr_rand.sv
// lfsr_rand: Fibonacci LFSR random source with a req/valid draw port that
// returns a uniform value below a runtime limit via masked rejection sampling.
// Ports: clk, rst (async, active-low), seed_we/seed_in (seed load),
//   free_run (advance every edge), req/limit (draw request),
//   busy/valid/rand_out/fallback (draw status/result),
//   lockup (zero-state recovery pulse), state_out (LFSR state).
`timescale 1ns/1ps
module lfsr_rand #(
  parameter int                WIDTH     = 16,
  parameter logic [WIDTH-1:0]  TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED      = 16'h5EED,
  parameter int                OUT_W     = 8,
  parameter int                MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             free_run,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rand_out,
  output logic             fallback,
  output logic             lockup,
  output logic [WIDTH-1:0] state_out
);

  localparam int TW = $clog2(MAX_TRIES) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0] lim_q, lim_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] rand_q, rand_d;
  logic             fall_q, fall_d;
  logic             lock_q, lock_d;

  logic             fbit;
  logic [OUT_W-1:0] lim_m1;
  logic [OUT_W-1:0] new_mask;
  logic [OUT_W-1:0] cand;
  logic             take;
  logic             advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      lfsr_q  <= SEED;
      lim_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      valid_q <= 1'b0;
      rand_q  <= '0;
      fall_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      valid_q <= valid_d;
      rand_q  <= rand_d;
      fall_q  <= fall_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    valid_d = 1'b0;
    rand_d  = rand_q;
    fall_d  = fall_q;
    lock_d  = 1'b0;

    fbit = ^(lfsr_q & TAPS);

    // Smear limit-1 downward: every bit at or below its MSB is set.
    lim_m1   = limit - OUT_W'(1);
    new_mask = '0;
    for (int i = 0; i < OUT_W; i++) begin
      new_mask[i] = |(lim_m1 >> i);
    end
    if (limit <= OUT_W'(1)) begin
      new_mask = '1;
    end

    cand = lfsr_q[OUT_W-1:0] & mask_q;

    // A req during the valid cycle is dropped, not queued.
    take    = (fsm_q == IDLE) && req && !valid_q;
    advance = free_run || (fsm_q == DRAW) || take;

    unique case (fsm_q)
      IDLE: begin
        if (take) begin
          fsm_d   = DRAW;
          lim_d   = limit;
          mask_d  = new_mask;
          tries_d = '0;
        end
      end
      DRAW: begin
        if ((lim_q == '0) || (cand < lim_q)) begin
          rand_d  = cand;
          valid_d = 1'b1;
          fall_d  = 1'b0;
          fsm_d   = IDLE;
        end else if (tries_q == TW'(MAX_TRIES - 1)) begin
          rand_d  = lim_q - OUT_W'(1);
          valid_d = 1'b1;
          fall_d  = 1'b1;
          fsm_d   = IDLE;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (seed_we) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED;
      lock_d = 1'b1;
    end else if (advance) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fbit};
    end
  end

  assign busy      = (fsm_q == DRAW);
  assign valid     = valid_q;
  assign rand_out  = rand_q;
  assign fallback  = fall_q;
  assign lockup    = lock_q;
  assign state_out = lfsr_q;

endmodule
